// File: rtl/ebpc_enc_arbiter.sv
// Frame-granular round-robin arbiter sharing one EBPC encoder between N_IN input streams.
// Optional statistics counters are built when EBPC_ENC_ARB_STATS_EN is defined.
module ebpc_enc_arbiter #(
    parameter  int N_IN   = 4,
    parameter  int DATA_W = 8,
    localparam int ID_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_IN*DATA_W-1:0] in_data_i,
    input  logic [N_IN-1:0]        in_last_i,
    input  logic [N_IN-1:0]        in_vld_i,
    output logic [N_IN-1:0]        in_rdy_o,
    output logic [DATA_W-1:0]      enc_data_o,
    output logic                   enc_last_o,
    output logic                   enc_vld_o,
    input  logic                   enc_rdy_i,
    input  logic                   enc_idle_i,
    input  logic                   znz_last_i,
    input  logic                   znz_vld_i,
    input  logic                   znz_rdy_i,
    input  logic                   bpc_last_i,
    input  logic                   bpc_vld_i,
    input  logic                   bpc_rdy_i,
    output logic [ID_W-1:0]        owner_id_o,
    output logic                   owner_vld_o,
    output logic                   busy_o,
    output logic [1:0]             state_o
`ifdef EBPC_ENC_ARB_STATS_EN
    ,
    output logic [N_IN*16-1:0]     frame_cnt_o,
    output logic [15:0]            stall_cnt_o
`endif
);

    // Handshakes: a beat transfers in a cycle where vld and rdy are both high; the
    // sender keeps data/last stable while vld is high and rdy is low.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] owner_q;
    logic            owner_vld_q;
    logic            znz_done_q;
    logic            bpc_done_q;

    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic [ID_W-1:0]   hi_idx;
    logic              hi_found;
    logic [ID_W-1:0]   rr_next;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              sel_vld;
    logic              znz_hs;
    logic              bpc_hs;
    logic              drain_exit;

    // First requester at or above rr_ptr wins; otherwise the lowest index wraps around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        for (int j = N_IN - 1; j >= 0; j--) begin
            if (in_vld_i[j]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(j);
                if (ID_W'(j) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(j);
                end
            end
        end
        if (hi_found) begin
            grant_idx = hi_idx;
        end
    end

    always_comb begin
        if (owner_q == ID_W'(N_IN - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = owner_q + ID_W'(1);
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_vld  = 1'b0;
        for (int j = 0; j < N_IN; j++) begin
            if (owner_q == ID_W'(j)) begin
                sel_data = in_data_i[j*DATA_W +: DATA_W];
                sel_last = in_last_i[j];
                sel_vld  = in_vld_i[j];
            end
        end
    end

    // Owner path is purely combinational so the encoder sees no extra latency.
    always_comb begin
        enc_data_o = '0;
        enc_last_o = 1'b0;
        enc_vld_o  = 1'b0;
        in_rdy_o   = '0;
        if (state_q == STREAM) begin
            enc_data_o = sel_data;
            enc_last_o = sel_last;
            enc_vld_o  = sel_vld;
            for (int j = 0; j < N_IN; j++) begin
                if (owner_q == ID_W'(j)) begin
                    in_rdy_o[j] = enc_rdy_i;
                end
            end
        end
    end

    assign znz_hs     = znz_vld_i && znz_rdy_i && znz_last_i;
    assign bpc_hs     = bpc_vld_i && bpc_rdy_i && bpc_last_i;
    // A last seen in this very cycle counts towards releasing the encoder.
    assign drain_exit = (state_q == DRAIN) && (znz_done_q || znz_hs)
                        && (bpc_done_q || bpc_hs) && enc_idle_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            znz_done_q  <= 1'b0;
            bpc_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        owner_q     <= grant_idx;
                        owner_vld_q <= 1'b1;
                        znz_done_q  <= 1'b0;
                        bpc_done_q  <= 1'b0;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (znz_hs) znz_done_q <= 1'b1;
                    if (bpc_hs) bpc_done_q <= 1'b1;
                    if (enc_vld_o && enc_rdy_i && enc_last_o) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (znz_hs) znz_done_q <= 1'b1;
                    if (bpc_hs) bpc_done_q <= 1'b1;
                    if (drain_exit) begin
                        state_q     <= IDLE;
                        owner_vld_q <= 1'b0;
                        rr_ptr_q    <= rr_next;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    owner_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign owner_id_o  = owner_q;
    assign owner_vld_o = owner_vld_q;
    assign busy_o      = owner_vld_q;
    assign state_o     = state_q;

`ifdef EBPC_ENC_ARB_STATS_EN
    logic [15:0] frame_cnt_q [N_IN];
    logic [15:0] stall_cnt_q;

    // Frame counters wrap; the stall counter saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < N_IN; j++) begin
                frame_cnt_q[j] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int j = 0; j < N_IN; j++) begin
                if (drain_exit && owner_q == ID_W'(j)) begin
                    frame_cnt_q[j] <= frame_cnt_q[j] + 16'd1;
                end
            end
            if (state_q == STREAM && enc_vld_o && !enc_rdy_i && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        frame_cnt_o = '0;
        for (int j = 0; j < N_IN; j++) begin
            frame_cnt_o[j*16 +: 16] = frame_cnt_q[j];
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/ebpc_enc_arbiter.md
Name: ebpc_enc_arbiter

Overview:
- Shares one EBPC encoder instance between N_IN independent input streams. Arbitration is at frame granularity.
- A requester owns the encoder from grant until its frame has fully drained, i.e. both the ZNZ and BPC output streams have handshaked their last beat and the encoder reports idle.
- Exports the owner ID alongside the encoder output streams so the downstream packer can tag the streams.
- Sits between the input DMA ports and the encoder's data/last/vld/rdy input.

Parameters:
- N_IN, 4, number of requesting input streams (2..16).
- DATA_W, 8, word width; must match the encoder data width.
- Derived localparam ID_W = max(1, $clog2(N_IN)).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- in_data_i  in  N_IN x DATA_W  per-requester data
- in_last_i  in  N_IN  per-requester last-of-frame
- in_vld_i  in  N_IN  per-requester valid
- in_rdy_o  out  N_IN  per-requester ready
- enc_data_o  out  DATA_W  to encoder data_i
- enc_last_o  out  1  to encoder last_i
- enc_vld_o  out  1  to encoder vld_i
- enc_rdy_i  in  1  from encoder rdy_o
- enc_idle_i  in  1  from encoder idle_o
- znz_last_i / znz_vld_i / znz_rdy_i  in  1 each  monitor taps of the encoder ZNZ output handshake
- bpc_last_i / bpc_vld_i / bpc_rdy_i  in  1 each  monitor taps of the encoder BPC output handshake
- owner_id_o  out  ID_W  current owner index
- owner_vld_o  out  1  owner_id_o is meaningful
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, owner=0, znz_done=0, bpc_done=0. All outputs 0.
- States:
  - IDLE:
    - All in_rdy_o=0, enc_vld_o=0.
    - If any in_vld_i, pick the first set bit scanning from rr_ptr upward, with wrap modulo N_IN.
    - Register that index as owner; clear znz_done and bpc_done; go to STREAM.
    - This gives 1 cycle of arbitration latency.
    - The winner's word is not consumed in IDLE.
  - STREAM:
    - enc_data_o = in_data_i[owner], enc_last_o = in_last_i[owner], enc_vld_o = in_vld_i[owner].
    - in_rdy_o[owner] = enc_rdy_i; all other in_rdy_o = 0. The path is purely combinational, with no added latency.
    - On a handshake (enc_vld_o && enc_rdy_i) with enc_last_o=1, go to DRAIN.
  - DRAIN:
    - enc_vld_o=0; all in_rdy_o=0.
    - Exit to IDLE when znz_done && bpc_done && enc_idle_i.
    - On exit, rr_ptr = (owner+1) mod N_IN. When owner = N_IN-1, rr_ptr wraps to 0.
- Done flags:
  - znz_done is set on znz_vld_i && znz_rdy_i && znz_last_i, sampled in STREAM or DRAIN.
  - bpc_done is set likewise from the bpc_* taps.
  - Both flags are sticky until the next grant.
  - A flag and the DRAIN exit condition may evaluate in the same cycle: the combinational OR of the flag and the live handshake counts.
- Ownership outputs: owner_vld_o=1 in STREAM and DRAIN. owner_id_o is held constant from grant to DRAIN exit.
- Boundary conditions:
  - Single-word frame: last on the first beat goes STREAM→DRAIN after one handshake.
  - All-zero frame: the BPC last may arrive without any BPC data beats. The bpc_done rule still applies; there is no special case.
  - The owner may deassert in_vld_i mid-frame: stay in STREAM with enc_vld_o=0. There is no timeout and no preemption.
  - Non-owner valids are ignored; their in_rdy_o stays 0 and their data must be held by them.
  - N_IN=1: the arbiter degenerates, but the DRAIN wait still applies.
  - Reset mid-frame: immediate return to IDLE. The encoder shares rst_ni, so no partial-frame recovery is needed.

Optional Feature:
- Macro: EBPC_ENC_ARB_STATS_EN.
- When defined:
  - Adds output frame_cnt_o, N_IN x 16, one counter per requester.
  - A counter increments on DRAIN exit for the owner. It wraps 0xFFFF→0x0000 and resets to 0.
  - Adds output stall_cnt_o, 16 bits: counts STREAM cycles with enc_vld_o=1 && enc_rdy_i=0. It saturates at 0xFFFF.
- When undefined: neither port exists, and no counter logic is generated.

Test Plan:
- Only input 2 valid with a 3-word frame {0x05,0x00,0x7F}, last on 0x7F → grant 1 cycle after valid; owner_id_o=2; 3 encoder handshakes; DRAIN until both output lasts are seen and enc_idle_i=1; then IDLE with rr_ptr=3.
- All 4 inputs continuously valid, 1-word frames → grant order 0,1,2,3,0; no in_rdy_o asserted for non-owners at any cycle.
- Encoder rdy toggling 1,0,0,1 during a 4-word frame from input 1 → in_rdy_o[1] tracks enc_rdy_i exactly; every word is passed in order and none is duplicated.
- All-zero 8-word frame from input 0 with the BPC last arriving 1 cycle before the ZNZ last → DRAIN exit on the cycle after the later last with enc_idle_i=1; owner_vld_o stays 1 throughout DRAIN.
- rst_ni pulsed low mid-STREAM on the 2nd word → all outputs 0 asynchronously; after release the state is IDLE with rr_ptr=0.
- EBPC_ENC_ARB_STATS_EN defined, 3 frames from input 3 with 5 enc_rdy_i-low cycles → frame_cnt_o[3]=3, others 0, stall_cnt_o=5.
